sevenseg_scan: RTL and testbench

Parametrised multiplexed seven-segment display driver for board-level status and debug readouts. It scans NUM_DIGITS common-anode digits and double-buffers the display data so updates never tear mid-frame. It also provides per-digit blanking, leading-zero suppression and PWM brightness. It sits between any hex-valued status source and the board segment, anode and decimal-point pins.

---
 rtl/sevenseg_scan.sv | 239 +++++++++++++++++++++++
 tb/tb_sevenseg_scan.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/sevenseg_scan.sv
`default_nettype none
// ============================================================================
//  Module   : sevenseg_scan
//  Brief    : Multiplexed common-anode seven-segment driver with double-
//             buffered display data, per-digit blanking, leading-zero
//             suppression and PWM brightness. All pin outputs are registered.
//             Optional feature macro: SEVENSEG_BLINK_EN adds a blink_mask
//             input and a BLINK_LOG2-bit frame counter that gates the
//             selected anodes off while the counter MSB is set.
//  Revision : 1.0 - initial release
// ============================================================================
module sevenseg_scan #(
  parameter int NUM_DIGITS    = 4,
  parameter int PRESCALE_BITS = 15,
`ifdef SEVENSEG_BLINK_EN
  parameter int BLINK_LOG2    = 6,
`endif
  parameter int BRIGHT_BITS   = 4
) (
  input  logic                    clk1,
  input  logic                    rst1,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    lzs,
  input  logic [BRIGHT_BITS-1:0]  bright,
`ifdef SEVENSEG_BLINK_EN
  input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
  output logic [6:0]              seg1,
  output logic [NUM_DIGITS-1:0]   an1,
  output logic                    dp1,
  output logic                    frame_tick,
  output logic                    upd_pend
);

  localparam int                IDX_W    = $clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  // Scan position
  logic [PRESCALE_BITS-1:0] pre_q, pre_d;
  logic [IDX_W-1:0]         idx_q, idx_d;

  // Pending and active display buffers
  logic [4*NUM_DIGITS-1:0]  pend_data_q, pend_data_d;
  logic [NUM_DIGITS-1:0]    pend_dp_q, pend_dp_d;
  logic [NUM_DIGITS-1:0]    pend_blank_q, pend_blank_d;
  logic [4*NUM_DIGITS-1:0]  act_data_q, act_data_d;
  logic [NUM_DIGITS-1:0]    act_dp_q, act_dp_d;
  logic [NUM_DIGITS-1:0]    act_blank_q, act_blank_d;
  logic                     upd_pend_q, upd_pend_d;

  // Frame tick is delayed twice from the boundary so it lines up with the
  // registered pins showing digit 0 of the new frame.
  logic                     new_frame_q, new_frame_d;
  logic                     frame_tick_q, frame_tick_d;

  // Registered pins
  logic [6:0]               seg1_q, seg1_d;
  logic [NUM_DIGITS-1:0]    an1_q, an1_d;
  logic                     dp1_q, dp1_d;

`ifdef SEVENSEG_BLINK_EN
  logic [BLINK_LOG2-1:0]    blink_cnt_q, blink_cnt_d;
`endif

  // Scan decode helpers
  logic                     slot_end;
  logic                     boundary;
  logic [3:0]               cur_nib;
  logic                     cur_dp;
  logic                     cur_blank;
  logic                     cur_supp;
  logic                     cur_blink_off;
  logic                     zero_run;
  logic                     lit;

  // Standard hex glyphs, segments {g,f,e,d,c,b,a}, active low
  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0:    g = 7'h40;
      4'h1:    g = 7'h79;
      4'h2:    g = 7'h24;
      4'h3:    g = 7'h30;
      4'h4:    g = 7'h19;
      4'h5:    g = 7'h12;
      4'h6:    g = 7'h02;
      4'h7:    g = 7'h78;
      4'h8:    g = 7'h00;
      4'h9:    g = 7'h10;
      4'hA:    g = 7'h08;
      4'hB:    g = 7'h03;
      4'hC:    g = 7'h46;
      4'hD:    g = 7'h21;
      4'hE:    g = 7'h06;
      default: g = 7'h0E;
    endcase
    return g;
  endfunction

  // Next-state: prescaler, digit index, buffer transfers and pending flag
  always_comb begin
    slot_end = &pre_q;
    boundary = slot_end && (idx_q == LAST_IDX);

    pre_d = pre_q + 1'b1;
    idx_d = idx_q;
    if (slot_end) begin
      idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
    end

    pend_data_d  = pend_data_q;
    pend_dp_d    = pend_dp_q;
    pend_blank_d = pend_blank_q;
    if (load) begin
      pend_data_d  = data_in;
      pend_dp_d    = dp_in;
      pend_blank_d = blank_in;
    end

    // A load coinciding with the boundary bypasses the pending buffer
    act_data_d  = act_data_q;
    act_dp_d    = act_dp_q;
    act_blank_d = act_blank_q;
    upd_pend_d  = upd_pend_q;
    if (boundary) begin
      upd_pend_d = 1'b0;
      if (load) begin
        act_data_d  = data_in;
        act_dp_d    = dp_in;
        act_blank_d = blank_in;
      end else if (upd_pend_q) begin
        act_data_d  = pend_data_q;
        act_dp_d    = pend_dp_q;
        act_blank_d = pend_blank_q;
      end
    end else if (load) begin
      upd_pend_d = 1'b1;
    end

    new_frame_d  = boundary;
    frame_tick_d = new_frame_q;

`ifdef SEVENSEG_BLINK_EN
    blink_cnt_d = boundary ? blink_cnt_q + 1'b1 : blink_cnt_q;
`endif
  end

  // Pin decode: select the current digit, apply suppression, blank, PWM
  always_comb begin
    cur_nib       = 4'h0;
    cur_dp        = 1'b0;
    cur_blank     = 1'b1;
    cur_supp      = 1'b0;
    cur_blink_off = 1'b0;
    zero_run      = 1'b1;

    // Walk from the most significant digit down; a digit is suppressed
    // while every nibble from the top down to it is zero.
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run && (act_data_q[4*i +: 4] == 4'h0);
      if (idx_q == IDX_W'(i)) begin
        cur_nib   = act_data_q[4*i +: 4];
        cur_dp    = act_dp_q[i];
        cur_blank = act_blank_q[i];
        cur_supp  = lzs && (i != 0) && zero_run;
`ifdef SEVENSEG_BLINK_EN
        cur_blink_off = blink_cnt_q[BLINK_LOG2-1] && blink_mask[i];
`endif
      end
    end

    lit = !cur_blank && !cur_blink_off &&
          (bright > pre_q[PRESCALE_BITS-1 -: BRIGHT_BITS]);

    // While the anode is off, segments and dp are parked inactive
    seg1_d = 7'h7F;
    if (lit && !cur_supp) begin
      seg1_d = hex_glyph(cur_nib);
    end
    dp1_d = !(lit && cur_dp);

    an1_d = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      an1_d[i] = !(lit && (idx_q == IDX_W'(i)));
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk1) begin
    if (rst1) begin
      pre_q        <= '0;
      idx_q        <= '0;
      pend_data_q  <= '0;
      pend_dp_q    <= '0;
      pend_blank_q <= '1;
      act_data_q   <= '0;
      act_dp_q     <= '0;
      act_blank_q  <= '1;
      upd_pend_q   <= 1'b0;
      new_frame_q  <= 1'b0;
      frame_tick_q <= 1'b0;
      seg1_q       <= 7'h7F;
      an1_q        <= '1;
      dp1_q        <= 1'b1;
`ifdef SEVENSEG_BLINK_EN
      blink_cnt_q  <= '0;
`endif
    end else begin
      pre_q        <= pre_d;
      idx_q        <= idx_d;
      pend_data_q  <= pend_data_d;
      pend_dp_q    <= pend_dp_d;
      pend_blank_q <= pend_blank_d;
      act_data_q   <= act_data_d;
      act_dp_q     <= act_dp_d;
      act_blank_q  <= act_blank_d;
      upd_pend_q   <= upd_pend_d;
      new_frame_q  <= new_frame_d;
      frame_tick_q <= frame_tick_d;
      seg1_q       <= seg1_d;
      an1_q        <= an1_d;
      dp1_q        <= dp1_d;
`ifdef SEVENSEG_BLINK_EN
      blink_cnt_q  <= blink_cnt_d;
`endif
    end
  end

  assign seg1       = seg1_q;
  assign an1        = an1_q;
  assign dp1        = dp1_q;
  assign frame_tick = frame_tick_q;
  assign upd_pend   = upd_pend_q;

endmodule
`default_nettype wire

// File: tb/tb_sevenseg_scan.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sevenseg_scan
//  Brief    : Self-checking bench for sevenseg_scan (4 digits, 8-clock slots,
//             2-bit brightness) against a frame-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sevenseg_scan;

  localparam int ND     = 4;
  localparam int PB     = 3;
  localparam int BB     = 2;
  localparam int SLOT   = 1 << PB;
  localparam int FRAME  = ND * SLOT;

  logic            clk1 = 1'b0;
  logic            rst1 = 1'b1;
  logic            load = 1'b0;
  logic [4*ND-1:0] data_in = '0;
  logic [ND-1:0]   dp_in = '0;
  logic [ND-1:0]   blank_in = '0;
  logic            lzs = 1'b0;
  logic [BB-1:0]   bright = 2'd3;
  logic [6:0]      seg1;
  logic [ND-1:0]   an1;
  logic            dp1;
  logic            frame_tick;
  logic            upd_pend;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: buffers as per-digit arrays, scan position as a
  // plain cycle count since reset release.
  int         m_cyc;
  logic [3:0] m_act_nib [ND];
  logic       m_act_dp  [ND];
  logic       m_act_blk [ND];
  logic [3:0] m_pnd_nib [ND];
  logic       m_pnd_dp  [ND];
  logic       m_pnd_blk [ND];
  logic       m_pend;
  logic [6:0] glyph_tab [16];

  always #5 clk1 = ~clk1;

  sevenseg_scan #(
    .NUM_DIGITS    (ND),
    .PRESCALE_BITS (PB),
    .BRIGHT_BITS   (BB)
  ) dut (
    .clk1       (clk1),
    .rst1       (rst1),
    .load       (load),
    .data_in    (data_in),
    .dp_in      (dp_in),
    .blank_in   (blank_in),
    .lzs        (lzs),
    .bright     (bright),
`ifdef SEVENSEG_BLINK_EN
    .blink_mask ('0),
`endif
    .seg1       (seg1),
    .an1        (an1),
    .dp1        (dp1),
    .frame_tick (frame_tick),
    .upd_pend   (upd_pend)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d, t=%0t)", tag, obs, exp, m_cyc, $time);
    end
  endtask

  task automatic model_reset();
    m_cyc  = 0;
    m_pend = 1'b0;
    for (int i = 0; i < ND; i++) begin
      m_act_nib[i] = 4'h0; m_act_dp[i] = 1'b0; m_act_blk[i] = 1'b1;
      m_pnd_nib[i] = 4'h0; m_pnd_dp[i] = 1'b0; m_pnd_blk[i] = 1'b1;
    end
  endtask

  // Hold reset for n clocks, checking the reset values each clock
  task automatic do_reset(input int n);
    rst1 = 1'b1;
    load = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk1); #1;
      check("rst_seg", 32'(seg1), 32'h7F);
      check("rst_an", 32'(an1), 32'hF);
      check("rst_dp", 32'(dp1), 32'h1);
      check("rst_tick", 32'(frame_tick), 32'h0);
      check("rst_pend", 32'(upd_pend), 32'h0);
    end
    rst1 = 1'b0;
    model_reset();
  endtask

  // One clock: drive inputs, predict pins from the current model state,
  // advance the model, clock, compare.
  task automatic tick(input logic ld, input logic [4*ND-1:0] d, input logic [ND-1:0] dpv,
                      input logic [ND-1:0] blk, input logic lz, input logic [BB-1:0] br);
    int         p, i;
    logic       on, supp, zeros, bnd;
    logic [6:0] e_seg;
    logic [ND-1:0] e_an;
    logic       e_dp, e_tick;

    load = ld; data_in = d; dp_in = dpv; blank_in = blk; lzs = lz; bright = br;

    p = m_cyc % SLOT;
    i = (m_cyc / SLOT) % ND;
    zeros = 1'b1;
    for (int k = i; k < ND; k++) zeros = zeros && (m_act_nib[k] == 4'h0);
    supp  = lz && (i >= 1) && zeros;
    on    = !m_act_blk[i] && (int'(br) > (p >> (PB - BB)));
    e_seg = (on && !supp) ? glyph_tab[m_act_nib[i]] : 7'h7F;
    e_an  = on ? ~(ND'(1) << i) : '1;
    e_dp  = !(on && m_act_dp[i]);
    e_tick = (m_cyc > 0) && (m_cyc % FRAME == 0);

    bnd = (m_cyc % FRAME == FRAME - 1);
    if (ld) begin
      for (int k = 0; k < ND; k++) begin
        m_pnd_nib[k] = d[4*k +: 4]; m_pnd_dp[k] = dpv[k]; m_pnd_blk[k] = blk[k];
      end
    end
    if (bnd) begin
      if (ld || m_pend) begin
        for (int k = 0; k < ND; k++) begin
          m_act_nib[k] = m_pnd_nib[k]; m_act_dp[k] = m_pnd_dp[k]; m_act_blk[k] = m_pnd_blk[k];
        end
      end
      m_pend = 1'b0;
    end else if (ld) begin
      m_pend = 1'b1;
    end
    m_cyc++;

    @(posedge clk1); #1;
    check("seg", 32'(seg1), 32'(e_seg));
    check("an", 32'(an1), 32'(e_an));
    check("dp", 32'(dp1), 32'(e_dp));
    check("tick", 32'(frame_tick), 32'(e_tick));
    check("pend", 32'(upd_pend), 32'(m_pend));
    check("an_onecold", 32'($countones(~an1) <= 1), 32'h1);
  endtask

  task automatic idle(input int n, input logic lz, input logic [BB-1:0] br);
    for (int k = 0; k < n; k++) tick(1'b0, data_in, dp_in, blank_in, lz, br);
  endtask

  task automatic idle_to_boundary(input logic lz, input logic [BB-1:0] br);
    while (m_cyc % FRAME != FRAME - 1) tick(1'b0, data_in, dp_in, blank_in, lz, br);
  endtask

  initial begin
    logic [4*ND-1:0] rd;
    glyph_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    model_reset();
    do_reset(3);

    // Dark first frames, tick every FRAME clocks
    idle(2 * FRAME + 3, 1'b0, 2'd3);

    // Basic load with a decimal point on digit 2
    tick(1'b1, 16'h12AF, 4'b0100, 4'b0000, 1'b0, 2'd3);
    idle(2 * FRAME, 1'b0, 2'd3);

    // Two loads in one frame: only the second is shown
    idle_to_boundary(1'b0, 2'd3);
    idle(2, 1'b0, 2'd3);
    tick(1'b1, 16'h1111, 4'b0000, 4'b0000, 1'b0, 2'd3);
    idle(5, 1'b0, 2'd3);
    tick(1'b1, 16'h2222, 4'b0000, 4'b0000, 1'b0, 2'd3);
    idle(2 * FRAME, 1'b0, 2'd3);

    // Load exactly on the boundary cycle
    idle_to_boundary(1'b0, 2'd3);
    tick(1'b1, 16'h3C9D, 4'b1001, 4'b0010, 1'b0, 2'd3);
    idle(FRAME + 4, 1'b0, 2'd3);

    // Leading-zero suppression
    tick(1'b1, 16'h0050, 4'b1000, 4'b0000, 1'b1, 2'd3);
    idle(2 * FRAME, 1'b1, 2'd3);
    tick(1'b1, 16'h0000, 4'b0000, 4'b0000, 1'b1, 2'd3);
    idle(2 * FRAME, 1'b1, 2'd3);

    // Brightness extremes
    tick(1'b1, 16'h8E67, 4'b0000, 4'b0000, 1'b0, 2'd1);
    idle(2 * FRAME, 1'b0, 2'd1);
    idle(FRAME, 1'b0, 2'd0);
    idle(FRAME, 1'b0, 2'd2);

    // Reset mid-frame with a pending load: data must be discarded
    idle(7, 1'b0, 2'd3);
    tick(1'b1, 16'h4567, 4'b1111, 4'b0000, 1'b0, 2'd3);
    do_reset(2);
    idle(2 * FRAME, 1'b0, 2'd3);

    // Randomised traffic
    for (int n = 0; n < 1500; n++) begin
      logic       ld, lz;
      logic [BB-1:0] br;
      lz = (n / 200) % 2 == 1;
      br = BB'($urandom_range(0, 3));
      ld = ($urandom_range(0, 15) == 0) || ((m_cyc % FRAME == FRAME - 1) && $urandom_range(0, 2) == 0);
      for (int k = 0; k < ND; k++)
        rd[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      tick(ld, rd, ND'($urandom), ($urandom_range(0, 3) == 0) ? ND'($urandom) : '0, lz, br);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
